// File: rtl/elastic_shift_register_if.sv
// Handshake bundle for the elastic shift register: the upstream entry port
// and the downstream delivery port, each with its own valid/ready pair.
interface elastic_shift_register_if #(
  parameter int WIDTH = 8
);
  logic             in_vld;
  logic             in_rdy;
  logic [WIDTH-1:0] in_data;
  logic             out_vld;
  logic             out_rdy;
  logic [WIDTH-1:0] out_data;

  // The pipe itself: consumes entries upstream, produces them downstream.
  modport slave (
    input  in_vld, in_data, out_rdy,
    output in_rdy, out_vld, out_data
  );

  // The surrounding logic: produces entries and accepts deliveries.
  modport master (
    output in_vld, in_data, out_rdy,
    input  in_rdy, out_vld, out_data
  );
endinterface

// File: rtl/elastic_shift_register.sv
// DEPTH-stage elastic delay line. Every stage carries its own valid bit and
// advances whenever the stage ahead of it can take an entry, so a stall at
// the output only holds back the full stages behind it and bubbles collapse.
module elastic_shift_register #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  elastic_shift_register_if.slave bus,
  output logic [CNT_W-1:0]        count
);

  logic [WIDTH-1:0] data [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] r;
  logic [DEPTH-1:0] take;
  logic [DEPTH-1:0] leave;
  logic [DEPTH-1:0] vld_next;
  logic [DEPTH-1:0] mask;
  logic             in_xfer;
  logic             out_xfer;

  // Stage ready: a stage can accept if it or any stage ahead of it is empty,
  // or the consumer is taking. Written in closed form so there is no
  // self-referencing vector in the ripple chain.
  always_comb begin
    r    = '0;
    mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      mask = (DEPTH'(1) << i) - DEPTH'(1);
      r[i] = bus.out_rdy | ~(&(vld | mask));
    end
  end

  assign bus.in_rdy   = r[0] & ~flush;
  assign in_xfer      = bus.in_vld & bus.in_rdy;
  assign out_xfer     = vld[DEPTH-1] & bus.out_rdy;
  assign bus.out_vld  = vld[DEPTH-1];
  assign bus.out_data = data[DEPTH-1];

  // Per-stage moves: take marks a stage loading from behind, leave marks a
  // stage handing its entry forward (or out of the pipe for the last stage).
  always_comb begin
    take  = '0;
    leave = '0;
    take[0] = in_xfer;
    for (int i = 1; i < DEPTH; i++) begin
      take[i] = vld[i-1] & r[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      leave[i] = vld[i] & r[i+1];
    end
    leave[DEPTH-1] = out_xfer;
    vld_next = take | (vld & ~leave);
  end

  // Stage state and occupancy; data registers only load on a transfer in.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data[i] <= '0;
      end
    end else begin
      vld   <= flush ? '0 : vld_next;
      count <= flush ? '0 : count + CNT_W'(in_xfer) - CNT_W'(out_xfer);
      if (take[0]) begin
        data[0] <= bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (take[i]) begin
          data[i] <= data[i-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_elastic_shift_register.sv
// Directed bench for elastic_shift_register with WIDTH=8, DEPTH=4.
// Inputs change on the falling edge; outputs are sampled 1ns later, which
// shows the combinational in_rdy and the state left by the previous edge.
module tb_elastic_shift_register;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             flush;
  logic [CNT_W-1:0] count;

  elastic_shift_register_if #(.WIDTH(WIDTH)) bus ();

  elastic_shift_register #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             flush;
    logic             in_vld;
    logic [WIDTH-1:0] in_data;
    logic             out_rdy;
    logic             exp_in_rdy;
    logic             exp_out_vld;
    logic [WIDTH-1:0] exp_out_data;
    logic [CNT_W-1:0] exp_count;
  } vec_t;

  vec_t vecs[$];
  int   total_checks = 0;
  int   passed_checks = 0;

  function automatic void addVec(input logic fl, input logic iv, input logic [WIDTH-1:0] d,
                                 input logic ordy, input logic e_rdy, input logic e_vld,
                                 input logic [WIDTH-1:0] e_data, input logic [CNT_W-1:0] e_cnt);
    vec_t v;
    v.flush = fl; v.in_vld = iv; v.in_data = d; v.out_rdy = ordy;
    v.exp_in_rdy = e_rdy; v.exp_out_vld = e_vld; v.exp_out_data = e_data; v.exp_count = e_cnt;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_checks++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      passed_checks++;
    end
  endtask

  task automatic applyStimulus(input logic fl, input logic iv, input logic [WIDTH-1:0] d,
                               input logic ordy);
    @(negedge clk);
    flush       = fl;
    bus.in_vld  = iv;
    bus.in_data = d;
    bus.out_rdy = ordy;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic e_rdy, input logic e_vld,
                             input logic [WIDTH-1:0] e_data, input logic [CNT_W-1:0] e_cnt);
    check({tag, " in_rdy"}, 32'(bus.in_rdy), 32'(e_rdy));
    check({tag, " out_vld"}, 32'(bus.out_vld), 32'(e_vld));
    if (e_vld) begin
      check({tag, " out_data"}, 32'(bus.out_data), 32'(e_data));
    end
    check({tag, " count"}, 32'(count), 32'(e_cnt));
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_vld = 1'b0;
    bus.in_data = '0;
    bus.out_rdy = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset", 1'b1, 1'b0, 8'h00, 3'd0);
    check("reset out_data", 32'(bus.out_data), 32'h0);

    // Back-to-back stream 0x01..0x0A with the consumer always ready.
    addVec(0,1,8'h01,1, 1,0,8'h00,0);
    addVec(0,1,8'h02,1, 1,0,8'h00,1);
    addVec(0,1,8'h03,1, 1,0,8'h00,2);
    addVec(0,1,8'h04,1, 1,0,8'h00,3);
    addVec(0,1,8'h05,1, 1,1,8'h01,4);
    addVec(0,1,8'h06,1, 1,1,8'h02,4);
    addVec(0,1,8'h07,1, 1,1,8'h03,4);
    addVec(0,1,8'h08,1, 1,1,8'h04,4);
    addVec(0,1,8'h09,1, 1,1,8'h05,4);
    addVec(0,1,8'h0A,1, 1,1,8'h06,4);
    addVec(0,0,8'h00,1, 1,1,8'h07,4);
    addVec(0,0,8'h00,1, 1,1,8'h08,3);
    addVec(0,0,8'h00,1, 1,1,8'h09,2);
    addVec(0,0,8'h00,1, 1,1,8'h0A,1);
    addVec(0,0,8'h00,1, 1,0,8'h00,0);
    // Fill against a stalled consumer, then drain in order.
    addVec(0,1,8'h01,0, 1,0,8'h00,0);
    addVec(0,1,8'h02,0, 1,0,8'h00,1);
    addVec(0,1,8'h03,0, 1,0,8'h00,2);
    addVec(0,1,8'h04,0, 1,0,8'h00,3);
    addVec(0,1,8'h05,0, 0,1,8'h01,4);
    addVec(0,1,8'h05,0, 0,1,8'h01,4);
    addVec(0,1,8'h05,1, 1,1,8'h01,4);
    addVec(0,1,8'h06,1, 1,1,8'h02,4);
    addVec(0,0,8'h00,1, 1,1,8'h03,4);
    addVec(0,0,8'h00,1, 1,1,8'h04,3);
    addVec(0,0,8'h00,1, 1,1,8'h05,2);
    addVec(0,0,8'h00,1, 1,1,8'h06,1);
    addVec(0,0,8'h00,1, 1,0,8'h00,0);
    // Bubble collapse: 0x22 must close up behind a stalled 0x11.
    addVec(0,1,8'h11,0, 1,0,8'h00,0);
    addVec(0,0,8'h00,0, 1,0,8'h00,1);
    addVec(0,0,8'h00,0, 1,0,8'h00,1);
    addVec(0,1,8'h22,0, 1,0,8'h00,1);
    addVec(0,0,8'h00,0, 1,1,8'h11,2);
    addVec(0,0,8'h00,0, 1,1,8'h11,2);
    addVec(0,0,8'h00,0, 1,1,8'h11,2);
    addVec(0,0,8'h00,0, 1,1,8'h11,2);
    addVec(0,0,8'h00,1, 1,1,8'h11,2);
    addVec(0,0,8'h00,1, 1,1,8'h22,1);
    addVec(0,0,8'h00,1, 1,0,8'h00,0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].flush, vecs[i].in_vld, vecs[i].in_data, vecs[i].out_rdy);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_in_rdy, vecs[i].exp_out_vld,
                  vecs[i].exp_out_data, vecs[i].exp_count);
    end

    // Flush with three entries inside and a competing input.
    applyStimulus(0, 1, 8'hA1, 0); checkOutput("flush fill0", 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'hA2, 0); checkOutput("flush fill1", 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'hA3, 0); checkOutput("flush fill2", 1, 0, 8'h00, 2);
    applyStimulus(1, 1, 8'hEE, 0); checkOutput("flush cycle", 0, 0, 8'h00, 3);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput($sformatf("post flush%0d", i), 1, 0, 8'h00, 0);
    end

    // Reset in the middle of a stream, then a fresh entry's latency.
    applyStimulus(0, 1, 8'hB1, 0); checkOutput("rst fill0", 1, 0, 8'h00, 0);
    applyStimulus(0, 1, 8'hB2, 0); checkOutput("rst fill1", 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 8'hB3, 0); checkOutput("rst fill2", 1, 0, 8'h00, 2);
    applyStimulus(0, 0, 8'h00, 0); checkOutput("rst full3", 1, 0, 8'h00, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("mid reset", 1, 0, 8'h00, 0);
    check("mid reset out_data", 32'(bus.out_data), 32'h0);
    applyStimulus(0, 1, 8'h55, 1); checkOutput("lat push", 1, 0, 8'h00, 0);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(0, 0, 8'h00, 1);
      checkOutput($sformatf("lat wait%0d", i), 1, 0, 8'h00, 1);
    end
    applyStimulus(0, 0, 8'h00, 1); checkOutput("lat out", 1, 1, 8'h55, 1);
    applyStimulus(0, 0, 8'h00, 1); checkOutput("lat done", 1, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
